// File: rtl/mul_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
package mul_pkg;

  // Default operand width and the matching iteration counter width.
  localparam int MUL_WIDTH = 32;
  localparam int CNT_W     = $clog2(MUL_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_t;

endpackage

// File: rtl/mul_add_shift.sv
// One shift-and-add iteration: conditional add of the multiplicand into the
// upper half, then a 1-bit right shift of {carry, acc, mq}.
module mul_add_shift #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] mq,
  input  logic [WIDTH-1:0] mcand,
  output logic [WIDTH-1:0] acc_nxt,
  output logic [WIDTH-1:0] mq_nxt
);

  logic [WIDTH:0] sum;

  // Add when the current multiplier LSB is set, keep the carry, shift right.
  always_comb begin
    sum = {1'b0, acc};
    if (mq[0]) sum = {1'b0, acc} + {1'b0, mcand};
    acc_nxt = sum[WIDTH:1];
    mq_nxt  = {sum[0], mq[WIDTH-1:1]};
  end

endmodule

// File: rtl/mul_seq_32.sv
// Sequential WIDTH x WIDTH multiplier, one partial product per cycle.
// Optional macro MUL_SIGNED_EN: two's complement operands via magnitude
// multiply plus a final conditional negate (one extra FIX cycle).
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start
// RUN   | one add/shift iteration per cycle, count runs WIDTH-1 .. 0
// FIX   | negate the magnitude product when operand signs differed
// DONE  | done pulse; p/Z/N just loaded; start here chains straight to RUN
module mul_seq_32
  import mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p,
  output logic               Z,
  output logic               N
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mq_q, mq_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [PW-1:0]    p_q, p_d;
  logic             z_q, z_d;
  logic             n_q, n_d;
  logic [WIDTH-1:0] acc_nx, mq_nx;
`ifdef MUL_SIGNED_EN
  logic             neg_q, neg_d;
  logic [PW-1:0]    prod_mag;
`endif

  mul_add_shift #(.WIDTH(WIDTH)) u_add_shift (
    .acc     (acc_q),
    .mq      (mq_q),
    .mcand   (mcand_q),
    .acc_nxt (acc_nx),
    .mq_nxt  (mq_nx)
  );

`ifdef MUL_SIGNED_EN
  assign prod_mag = {acc_q, mq_q};
`endif

  // Next-state, datapath and result-register computation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    mcand_d = mcand_q;
    p_d     = p_q;
    done_d  = 1'b0;
`ifdef MUL_SIGNED_EN
    neg_d   = neg_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d = RUN;
          cnt_d   = CW'(WIDTH - 1);
          acc_d   = '0;
`ifdef MUL_SIGNED_EN
          mcand_d = a[WIDTH-1] ? -a : a;
          mq_d    = b[WIDTH-1] ? -b : b;
          neg_d   = a[WIDTH-1] ^ b[WIDTH-1];
`else
          mcand_d = a;
          mq_d    = b;
`endif
        end
      end
      RUN: begin
        acc_d = acc_nx;
        mq_d  = mq_nx;
        if (cnt_q == '0) begin
`ifdef MUL_SIGNED_EN
          state_d = FIX;
`else
          state_d = DONE;
          p_d     = {acc_nx, mq_nx};
          done_d  = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      FIX: begin
`ifdef MUL_SIGNED_EN
        state_d = DONE;
        p_d     = neg_q ? -prod_mag : prod_mag;
        done_d  = 1'b1;
`else
        state_d = IDLE;
`endif
      end
    endcase
    // Flags only move together with a new product so reset p=0 keeps Z=0.
    z_d    = done_d ? (p_d == '0) : z_q;
    n_d    = done_d ? p_d[PW-1]   : n_q;
    busy_d = (state_d == RUN) || (state_d == FIX);
  end

  // State and result registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mq_q    <= '0;
      mcand_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      p_q     <= '0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
`ifdef MUL_SIGNED_EN
      neg_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      mcand_q <= mcand_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      p_q     <= p_d;
      z_q     <= z_d;
      n_q     <= n_d;
`ifdef MUL_SIGNED_EN
      neg_q   <= neg_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign p    = p_q;
  assign Z    = z_q;
  assign N    = n_q;

endmodule

// File: tb/tb_mul_seq_32.sv
// Self-checking bench for mul_seq_32 against an arithmetic reference model.
module tb_mul_seq_32;

`ifdef MUL_SIGNED_EN
  localparam int LAT = 34;
`else
  localparam int LAT = 33;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] a, b;
  logic        busy, done, Z, N;
  logic [63:0] p;

  int total = 0;
  int bad   = 0;

  mul_seq_32 #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .p     (p),
    .Z     (Z),
    .N     (N)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y);
`ifdef MUL_SIGNED_EN
    longint sx, sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    return 64'(sx * sy);
`else
    logic [63:0] ux, uy;
    ux = {32'b0, x};
    uy = {32'b0, y};
    return ux * uy;
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Waits for done starting at cycle n0 (the next negedge is cycle n0).
  task automatic wait_done(input int n0, output int cyc, output bit busy_ok);
    cyc = -1;
    busy_ok = 1'b1;
    for (int n = n0; n <= LAT + 5; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        cyc = n;
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
  endtask

  task automatic check_result(input string tag, input logic [63:0] exp);
    chk({tag, ".p"}, p, exp);
    chk({tag, ".Z"}, 64'(Z), 64'(exp == 64'd0));
    chk({tag, ".N"}, 64'(N), 64'(exp[63]));
  endtask

  // Full operation from an idle position just after a negedge.
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input string tag);
    int cyc;
    bit bok;
    logic [63:0] exp;
    exp = model(x, y);
    start = 1'b1; a = x; b = y;
    @(posedge clk);
    #1 start = 1'b0; a = ~x; b = ~y;
    wait_done(1, cyc, bok);
    chk({tag, ".lat"}, 64'(cyc), 64'(LAT));
    chk({tag, ".busy_run"}, 64'(bok), 64'd1);
    chk({tag, ".busy_done"}, 64'(busy), 64'd0);
    check_result(tag, exp);
    @(negedge clk);
    chk({tag, ".done_width"}, 64'(done), 64'd0);
  endtask

  initial begin
    int cyc;
    bit bok;
    logic [31:0] ra, rb;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.done", 64'(done), 64'd0);
    chk("rst.p", p, 64'd0);
    chk("rst.Z", 64'(Z), 64'd0);
    chk("rst.N", 64'(N), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(32'd3, 32'd5, "3x5");
    run_op(32'd0, 32'hFFFF_FFFF, "0xmax");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, "maxxmax");
    run_op(32'hFFFF_FFFD, 32'd7, "m3x7");
    run_op(32'h8000_0000, 32'h8000_0000, "minxmin");
    run_op(32'd7, 32'h8000_0000, "7xmin");

    // Start during busy is ignored; then chain a new start in the DONE cycle.
    start = 1'b1; a = 32'd2; b = 32'd2;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1; a = 32'd9; b = 32'd9;
    @(posedge clk);
    #1 start = 1'b0; a = '0; b = '0;
    wait_done(6, cyc, bok);
    chk("ign.lat", 64'(cyc), 64'(LAT));
    chk("ign.busy_run", 64'(bok), 64'd1);
    check_result("ign", model(32'd2, 32'd2));
    start = 1'b1; a = 32'd6; b = 32'd7;
    @(posedge clk);
    #1 start = 1'b0; a = '0; b = '0;
    @(negedge clk);
    chk("b2b.done_width", 64'(done), 64'd0);
    chk("b2b.busy", 64'(busy), 64'd1);
    chk("b2b.p_hold", p, 64'd4);
    wait_done(2, cyc, bok);
    chk("b2b.lat", 64'(cyc), 64'(LAT));
    chk("b2b.busy_run", 64'(bok), 64'd1);
    check_result("b2b", 64'd42);
    @(negedge clk);

    // Asynchronous reset in the middle of a run.
    start = 1'b1; a = 32'd5; b = 32'd5;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst.busy", 64'(busy), 64'd0);
    chk("arst.done", 64'(done), 64'd0);
    chk("arst.p", p, 64'd0);
    chk("arst.Z", 64'(Z), 64'd0);
    chk("arst.N", 64'(N), 64'd0);
    #2 rst_n = 1'b1;
    bok = 1'b1;
    for (int n = 0; n < LAT + 5; n++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) bok = 1'b0;
    end
    chk("arst.quiet", 64'(bok), 64'd1);
    run_op(32'd10, 32'd10, "post_rst");

    // Randomised operands with a few forced corner values.
    for (int i = 0; i < 16; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 4 == 1) ra = 32'h8000_0000 | ra[3:0];
      if (i % 4 == 2) rb = 32'hFFFF_FFFF;
      if (i % 8 == 3) ra = 32'd1;
      run_op(ra, rb, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
